jtcop_obj_dma: RTL

Object-table DMA stage for the JTCOP sprite pipeline. Holds the CPU-visible 1k×16 object RAM and, on a CPU DMA trigger, copies the whole RAM into a table buffer. The object drawing engine reads that buffer through `tbl_addr`/`tbl_dout`. With double buffering, the copy lands in a back bank that becomes visible at the next vertical blank, so sprite data never changes mid-frame.

---
 rtl/jtcop_obj_dma_if.sv | 24 ++
 rtl/jtcop_obj_dma.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_dma_if.sv
// Bus bundle for the JTCOP object-table DMA stage: CPU object-RAM port,
// DMA trigger/busy, drawing-engine table port and the vertical blank input.
interface jtcop_obj_dma_if #(parameter int AW = 10);
   logic          lvbl;
   logic          cpu_cs;
   logic [AW-1:0] cpu_addr;
   logic [15:0]   cpu_dout;
   logic [1:0]    cpu_we;
   logic [15:0]   cpu_din;
   logic          dma_trig;
   logic          dma_busy;
   logic [AW-1:0] tbl_addr;
   logic [15:0]   tbl_dout;

   modport master (
      output lvbl, cpu_cs, cpu_addr, cpu_dout, cpu_we, dma_trig, tbl_addr,
      input  cpu_din, dma_busy, tbl_dout
   );

   modport slave (
      input  lvbl, cpu_cs, cpu_addr, cpu_dout, cpu_we, dma_trig, tbl_addr,
      output cpu_din, dma_busy, tbl_dout
   );
endinterface

// File: rtl/jtcop_obj_dma.sv
// Object RAM plus DMA copy into the sprite table buffer. Define JTCOP_OBJ_DBUF_EN
// for a double-buffered table whose back bank becomes visible at the next vblank.
module jtcop_obj_dma #(
   parameter int TBL_AW = 10
) (
   input  logic             clk,
   input  logic             rst,
   jtcop_obj_dma_if.slave   bus
);
   localparam int DEPTH = 1 << TBL_AW;

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

   state_t            state_q;
   logic [TBL_AW:0]   rd_addr_q;
   logic [TBL_AW:0]   rd_addr_d;
   logic [TBL_AW-1:0] wr_addr_q;
   logic              wr_vld_q;
   logic              pend_q;
   logic              busy_q;
   logic              start;
   logic [15:0]       rd_data;
   logic [15:0]       cpu_din_w;
   logic [15:0]       tbl_dout_q;

   assign rd_addr_d = rd_addr_q + (TBL_AW+1)'(1);
   // A pending trigger (or one arriving right now) restarts straight from FLUSH.
   assign start = (state_q == IDLE  && bus.dma_trig) ||
                  (state_q == FLUSH && (pend_q || bus.dma_trig));

   // Object RAM split into byte lanes so each lane honours its own write enable.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_byte
         logic [7:0] mem [0:DEPTH-1];
         logic [7:0] rd_b_q;
         logic [7:0] din_q;

         always_ff @(posedge clk) begin
            if (bus.cpu_cs && bus.cpu_we[gi])
               mem[bus.cpu_addr] <= bus.cpu_dout[gi*8 +: 8];
         end

         always_ff @(posedge clk) begin
            if (state_q == READ)
               rd_b_q <= mem[rd_addr_q[TBL_AW-1:0]];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               din_q <= 8'd0;
            else if (bus.cpu_cs)
               din_q <= mem[bus.cpu_addr];
         end

         assign rd_data[gi*8 +: 8]   = rd_b_q;
         assign cpu_din_w[gi*8 +: 8] = din_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_vld_q  <= 1'b0;
         pend_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         busy_q    <= (state_q != IDLE);
         wr_vld_q  <= (state_q == READ);
         wr_addr_q <= rd_addr_q[TBL_AW-1:0];
         case (state_q)
            IDLE: begin
               if (start) begin
                  rd_addr_q <= '0;
                  state_q   <= READ;
               end
            end
            READ: begin
               if (bus.dma_trig)
                  pend_q <= 1'b1;
               rd_addr_q <= rd_addr_d;
               if (rd_addr_d[TBL_AW])
                  state_q <= FLUSH;
            end
            FLUSH: begin
               if (start) begin
                  pend_q    <= 1'b0;
                  rd_addr_q <= '0;
                  state_q   <= READ;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef JTCOP_OBJ_DBUF_EN
   logic        front_q;
   logic        ready_q;
   logic        lvbl_q;
   logic [15:0] tbl_mem [0:2*DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_vld_q)
         tbl_mem[{~front_q, wr_addr_q}] <= rd_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tbl_dout_q <= 16'd0;
      else
         tbl_dout_q <= tbl_mem[{front_q, bus.tbl_addr}];
   end

   // Only a completed copy (registered ready) is swapped in at the vblank start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_q <= 1'b0;
         ready_q <= 1'b0;
         lvbl_q  <= 1'b1;
      end else begin
         lvbl_q <= bus.lvbl;
         if (lvbl_q && !bus.lvbl && ready_q) begin
            front_q <= ~front_q;
            ready_q <= 1'b0;
         end
         if (state_q == FLUSH)
            ready_q <= ~start;
         else if (start)
            ready_q <= 1'b0;
      end
   end
`else
   logic [15:0] tbl_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_vld_q)
         tbl_mem[wr_addr_q] <= rd_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tbl_dout_q <= 16'd0;
      else
         tbl_dout_q <= tbl_mem[bus.tbl_addr];
   end
`endif

   assign bus.cpu_din  = cpu_din_w;
   assign bus.dma_busy = busy_q;
   assign bus.tbl_dout = tbl_dout_q;
endmodule
